// File: rtl/ctrl_packet_encoder.sv
// ctrl_packet_encoder
//   Turns decoded accelerator commands into 30-bit control packets.
//   Accepted commands are classified as follows:
//     - Commands with valid==0 are discarded silently.
//     - Commands with op_code 3'b110 or 3'b111 are discarded, and drop_err
//       pulses on the following cycle.
//     - All other commands are encoded and queued behind one output
//       register stage.
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous, active-high reset
//   in_valid    decoded command offered
//   in_ready    command can be accepted (FIFO not full)
//   in_ctrl     decoded command, 29 bits:
//               {valid, unit_id[7:0], src_unit_id[7:0], op_code[2:0],
//                comp_type[1:0], addr[3:0], size[2:0]}
//   out_valid   encoded packet available
//   out_ready   downstream accepts packet
//   out_packet  encoded packet, 30 bits:
//               {unit_id[7:0], src_unit_id[7:0], ctrl[5:0], config[7:0]}
//   drop_err    one-cycle pulse, illegal op_code discarded
//   fifo_count  entries held in the FIFO (output register not included)
//   pkt_count   packets delivered since reset, wraps at 16 bits
module ctrl_packet_encoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [28:0]                   in_ctrl,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [29:0]                   out_packet,
  output logic                          drop_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   pkt_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [2:0] OP_COPY    = 3'd4;
  localparam logic [2:0] OP_ADD_VEC = 3'd5;

  // Packet layout:
  //   ctrl   = {op_code, comp_type, 1}
  //   config = {addr, size, parity}
  // The parity bit makes ctrl plus config carry an even number of ones.
  function automatic logic [29:0] f_encode(input logic [28:0] c);
    logic [5:0] v_ctrl;
    logic [6:0] v_cfg_hi;
    logic [7:0] v_src;
    v_ctrl   = {c[11:9], c[8:7], 1'b1};
    v_src    = (c[11:9] == OP_COPY || c[11:9] == OP_ADD_VEC) ? c[19:12] : c[27:20];
    v_cfg_hi = {c[6:3], c[2:0]};
    return {c[27:20], v_src, v_ctrl, v_cfg_hi, ^{v_ctrl, v_cfg_hi}};
  endfunction

  logic [29:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_out_valid;
  logic [29:0]   r_out_packet;
  logic          r_drop;
  logic [15:0]   r_pkt_count;

  logic          w_acc;
  logic          w_illegal;
  logic          w_legal;
  logic          w_out_free;
  logic          w_pop;
  logic          w_bypass;
  logic          w_push;
  logic [29:0]   w_enc;

  assign in_ready   = (r_count < DEPTH_C);
  assign w_acc      = in_valid && in_ready;
  assign w_illegal  = (in_ctrl[11:10] == 2'b11);
  assign w_legal    = w_acc && in_ctrl[28] && !w_illegal;
  assign w_enc      = f_encode(in_ctrl);

  // The output register can take new data when it is empty or is being
  // consumed this cycle.
  assign w_out_free = !r_out_valid || out_ready;
  assign w_pop      = w_out_free && (r_count != '0);

  // With an empty FIFO, a legal command goes straight to the output
  // register. This gives one-cycle latency. Ordering is preserved because
  // the bypass is only taken when nothing is queued ahead of the command.
  assign w_bypass   = w_out_free && (r_count == '0) && w_legal;
  assign w_push     = w_legal && !w_bypass;

  // FIFO storage holds data only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_enc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_out_valid  <= 1'b0;
      r_out_packet <= '0;
      r_drop       <= 1'b0;
      r_pkt_count  <= '0;
    end else begin
      r_drop <= w_acc && in_ctrl[28] && w_illegal;

      // FIFO_DEPTH is a power of two, so pointer wrap is natural overflow.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_pop) begin
        r_out_packet <= r_mem[r_rd_ptr];
        r_out_valid  <= 1'b1;
      end else if (w_bypass) begin
        r_out_packet <= w_enc;
        r_out_valid  <= 1'b1;
      end else if (w_out_free) begin
        r_out_valid  <= 1'b0;
      end

      if (r_out_valid && out_ready) r_pkt_count <= r_pkt_count + 16'd1;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_packet = r_out_packet;
  assign drop_err   = r_drop;
  assign fifo_count = r_count;
  assign pkt_count  = r_pkt_count;

endmodule

// File: tb/tb_ctrl_packet_encoder.sv
module tb_ctrl_packet_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [28:0] in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [29:0] out_packet;
  logic        drop_err;
  logic [2:0]  fifo_count;
  logic [15:0] pkt_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [29:0] exp_q[$];
  logic [29:0] got_q[$];
  int          exp_drops = 0;
  int          seen_drops = 0;

  ctrl_packet_encoder #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out_packet(out_packet), .drop_err(drop_err), .fifo_count(fifo_count),
    .pkt_count(pkt_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [28:0] mk_cmd(input logic v, input logic [7:0] unit,
      input logic [7:0] src, input logic [2:0] op, input logic [1:0] comp,
      input logic [3:0] addr, input logic [2:0] size);
    return {v, unit, src, op, comp, addr, size};
  endfunction

  function automatic logic [28:0] rand_legal();
    return mk_cmd(1'b1, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 5)),
                  2'($urandom), 4'($urandom), 3'($urandom));
  endfunction

  // Reference packet built field-by-field from the encoding rules.
  function automatic logic [29:0] model_pkt(input logic [28:0] c);
    logic [7:0] unit, src, src_out;
    logic [2:0] op, size;
    logic [1:0] comp;
    logic [3:0] addr;
    logic [5:0] ctl;
    logic [6:0] cfg_hi;
    logic       par;
    {unit, src, op, comp, addr, size} = c[27:0];
    ctl     = {op, comp, 1'b1};
    src_out = (op == 3'd4 || op == 3'd5) ? src : unit;
    cfg_hi  = {addr, size};
    par     = (($countones({ctl, cfg_hi}) % 2) != 0);
    return {unit, src_out, ctl, cfg_hi, par};
  endfunction

  // Scoreboard feed: records accepted legal commands and delivered packets.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) got_q.push_back(out_packet);
      if (in_valid && in_ready && in_ctrl[28]) begin
        if (in_ctrl[11:9] >= 3'd6) exp_drops++;
        else exp_q.push_back(model_pkt(in_ctrl));
      end
      if (drop_err) seen_drops++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    exp_q.delete();
    got_q.delete();
    exp_drops  = 0;
    seen_drops = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_ctrl = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (out_packet !== 30'd0) begin n_fail++; $display("FAIL reset_out_packet got=%h exp=0", out_packet); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_fifo_count got=%0d exp=0", fifo_count); end
    n_checks++; if (pkt_count !== 16'd0) begin n_fail++; $display("FAIL reset_pkt_count got=%0d exp=0", pkt_count); end
    n_checks++; if (drop_err !== 1'b0) begin n_fail++; $display("FAIL reset_drop_err got=%b exp=0", drop_err); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    rst = 1'b0;
    step();
    flush();
  endtask

  task automatic test_single();
    out_ready = 1'b1; in_valid = 1'b1;
    in_ctrl = mk_cmd(1'b1, 8'h05, 8'h09, 3'd3, 2'b10, 4'hA, 3'd2);
    step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
    n_checks++; if (out_packet !== {8'h05, 8'h05, 6'b011101, 8'b1010_0101}) begin
      n_fail++; $display("FAIL single_packet got=%h exp=%h", out_packet, {8'h05, 8'h05, 6'b011101, 8'b1010_0101}); end
    step();
    n_checks++; if (pkt_count !== 16'd1) begin n_fail++; $display("FAIL single_pkt_count got=%0d exp=1", pkt_count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle got=%b exp=0", out_valid); end
  endtask

  task automatic test_copy();
    in_valid = 1'b1;
    in_ctrl = mk_cmd(1'b1, 8'h01, 8'h02, 3'd4, 2'b00, 4'h0, 3'd0);
    step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_packet !== {8'h01, 8'h02, 6'b100001, 8'h00}) begin
      n_fail++; $display("FAIL copy_packet got=%b/%h exp=1/%h", out_valid, out_packet, {8'h01, 8'h02, 6'b100001, 8'h00}); end
    step();
    n_checks++; if (pkt_count !== 16'd2) begin n_fail++; $display("FAIL copy_pkt_count got=%0d exp=2", pkt_count); end
  endtask

  task automatic test_backpressure();
    logic [29:0] hold;
    flush();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_ctrl = rand_legal();
      step();
    end
    in_valid = 1'b0;
    n_checks++; if (exp_q.size() != 5) begin n_fail++; $display("FAIL bp_accepted got=%0d exp=5", exp_q.size()); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL bp_fifo_count got=%0d exp=4", fifo_count); end
    hold = out_packet;
    step(); step();
    n_checks++; if (out_valid !== 1'b1 || out_packet !== hold) begin
      n_fail++; $display("FAIL bp_stall_stable got=%b/%h exp=1/%h", out_valid, out_packet, hold); end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_drain_valid beat=%0d got=%b exp=1", i, out_valid); end
      step();
    end
    n_checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
      n_fail++; $display("FAIL bp_empty got=%b/%0d exp=0/0", out_valid, fifo_count); end
    n_checks++; if (got_q.size() != 5) begin n_fail++; $display("FAIL bp_count got=%0d exp=5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_order idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_illegal();
    logic [15:0] pc;
    flush();
    out_ready = 1'b1;
    pc = pkt_count;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_ctrl = mk_cmd(1'b1, 8'($urandom), 8'($urandom), (k == 0) ? 3'b111 : 3'b110, 2'($urandom), 4'($urandom), 3'($urandom));
      step();
      in_valid = 1'b0;
      n_checks++; if (drop_err !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++; $display("FAIL illegal_pulse op=%0d got=%b/%b exp=1/0", k, drop_err, out_valid); end
      step();
      n_checks++; if (drop_err !== 1'b0) begin n_fail++; $display("FAIL illegal_one_cycle got=%b exp=0", drop_err); end
    end
    in_valid = 1'b1;
    in_ctrl = mk_cmd(1'b0, 8'h33, 8'h44, 3'd3, 2'b01, 4'h5, 3'd1);
    step();
    in_valid = 1'b0;
    n_checks++; if (drop_err !== 1'b0 || out_valid !== 1'b0 || fifo_count !== 3'd0) begin
      n_fail++; $display("FAIL invalid_silent got=%b/%b/%0d exp=0/0/0", drop_err, out_valid, fifo_count); end
    step();
    n_checks++; if (pkt_count !== pc || got_q.size() != 0) begin
      n_fail++; $display("FAIL illegal_no_packet got=%0d/%0d exp=%0d/0", pkt_count, got_q.size(), pc); end
  endtask

  task automatic test_reset_mid();
    logic [28:0] c;
    flush();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_ctrl = rand_legal();
      step();
    end
    in_valid = 1'b0;
    n_checks++; if (fifo_count !== 3'd3 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_preload got=%0d/%b exp=3/1", fifo_count, out_valid); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0 || pkt_count !== 16'd0 || out_packet !== 30'd0) begin
      n_fail++; $display("FAIL mid_async_clear got=%b/%0d/%0d/%h exp=0/0/0/0", out_valid, fifo_count, pkt_count, out_packet); end
    @(posedge clk);
    #1 rst = 1'b0;
    flush();
    out_ready = 1'b1;
    c = rand_legal();
    in_valid = 1'b1; in_ctrl = c;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    n_checks++; if (got_q.size() != 1 || got_q[0] !== model_pkt(c)) begin
      n_fail++; $display("FAIL mid_after_reset got=%0d pkts exp=1 pkt %h", got_q.size(), model_pkt(c)); end
  endtask

  task automatic test_random();
    logic        pv, pr;
    logic [29:0] pp;
    int          held;
    flush();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid  = ($urandom % 4) != 0;
      in_ctrl   = 29'($urandom);
      in_ctrl[28] = ($urandom % 8) != 0;
      out_ready = ($urandom % 3) != 0;
      pv = out_valid; pr = out_ready; pp = out_packet;
      step();
      held = exp_q.size() - got_q.size();
      n_checks++; if (in_ready !== (fifo_count < 3'd4)) begin
        n_fail++; $display("FAIL rand_in_ready cyc=%0d got=%b count=%0d", cyc, in_ready, fifo_count); end
      n_checks++; if (int'(fifo_count) + int'(out_valid) != held) begin
        n_fail++; $display("FAIL rand_occupancy cyc=%0d got=%0d+%0d exp=%0d", cyc, fifo_count, out_valid, held); end
      if (pv && !pr) begin
        n_checks++; if (out_valid !== 1'b1 || out_packet !== pp) begin
          n_fail++; $display("FAIL rand_stall cyc=%0d got=%b/%h exp=1/%h", cyc, out_valid, out_packet, pp); end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) step();
    n_checks++; if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_total got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rand_order idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); break; end
    end
    n_checks++; if (seen_drops != exp_drops) begin
      n_fail++; $display("FAIL rand_drops got=%0d exp=%0d", seen_drops, exp_drops); end
  endtask

  task automatic test_wrap();
    int guard;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b0;
    step();
    flush();
    // Stall first so the FIFO keeps two entries during streaming and its
    // pointers wrap many times.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_ctrl = rand_legal();
      step();
    end
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() < 65536 && guard < 70000) begin
      in_ctrl = rand_legal();
      step();
      guard++;
    end
    in_valid = 1'b0;
    n_checks++; if (guard >= 70000) begin n_fail++; $display("FAIL wrap_timeout accepted=%0d exp=65536", exp_q.size()); end
    for (int i = 0; i < 10 && out_valid; i++) begin
      step();
      n_checks++; if (pkt_count !== 16'(got_q.size())) begin
        n_fail++; $display("FAIL wrap_pkt_track got=%0d exp=%0d", pkt_count, 16'(got_q.size())); end
    end
    n_checks++; if (out_valid !== 1'b0 || got_q.size() != 65536) begin
      n_fail++; $display("FAIL wrap_drain got=%b/%0d exp=0/65536", out_valid, got_q.size()); end
    n_checks++; if (pkt_count !== 16'd0) begin n_fail++; $display("FAIL wrap_pkt_count got=%0d exp=0", pkt_count); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL wrap_order idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]); break; end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_copy();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
